mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-master, one-slave memory bus arbiter that shares the core's single-port memory between instruction fetch (master 0, read-only) and the execute-stage load/store path (master 1). It sits between ifetch/ex and the memory, serialises accesses with a req/gnt/ack handshake, arbitrates round-robin, and times out unresponsive accesses. It also raises a pipeline hold while a data access is outstanding.

## Interface
Parameters:
- TIMEOUT, 255: busy cycles without `s_ack_i` before the access is aborted (1..255)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- m0_req_i  in  1  fetch request
- m0_addr_i  in  32  fetch address
- m0_gnt_o  out  1  fetch request accepted (1-cycle pulse)
- m0_ack_o  out  1  fetch complete, `m0_rdata_o` valid (1-cycle pulse)
- m0_rdata_o  out  32  fetch data
- m0_err_o  out  1  fetch timed out (pulses with `m0_ack_o`)
- m1_req_i  in  1  load/store request
- m1_we_i  in  1  1 = store
- m1_addr_i  in  32  data address
- m1_wdata_i  in  32  store data
- m1_wmask_i  in  4  byte enables for store
- m1_gnt_o, m1_ack_o, m1_rdata_o, m1_err_o  out  1/1/32/1  as for master 0
- s_req_o  out  1  request to memory
- s_we_o  out  1  write enable
- s_addr_o  out  32  address
- s_wdata_o  out  32  write data
- s_wmask_o  out  4  byte enables (forced 4'b0000 for master 0)
- s_rdata_i  in  32  read data, valid with `s_ack_i`
- s_ack_i  in  1  memory completes the access
- hold_o  out  1  stall request to pc_reg / if_id / id_ex

## Operation
- States: IDLE, BUSY0, BUSY1. Register `last` (last granted master) and 8-bit `cnt`.
- IDLE:
  - One request pending: grant it.
  - Both pending: grant the master that is not `last`.
  - Grant cycle: `mX_gnt_o`=1 (combinational in IDLE), latch addr/we/wdata/wmask into the s_* registers, set `last`=X, `cnt`=0, next state BUSYX.
  - A master holds req and fields stable until gnt; it may re-assert req the cycle after gnt for a new access.
- BUSYX:
  - `s_req_o`=1 with the latched fields; `cnt` increments each cycle.
  - `s_ack_i`=1: register `s_rdata_i` into `mX_rdata_o`, pulse `mX_ack_o` next cycle, return to IDLE (`s_req_o` low next cycle).
  - `cnt`==TIMEOUT-1 without ack: abort. Next cycle `mX_ack_o`=1, `mX_err_o`=1, `mX_rdata_o`=0, state IDLE.
- `s_ack_i` in IDLE is ignored; it never generates an ack.
- Store acks return `mX_rdata_o`=s_rdata_i; the value is not used by the master.
- `m1_pend` is set on `m1_gnt_o` and cleared when `m1_ack_o` fires.
- `hold_o` = (`m1_req_i` | `m1_pend`) & ~`m1_ack_o`.
- No requests are ever queued beyond the single in-flight access.

## Timing
- Reset (rst_n=0 at an edge): state IDLE, `last`=1 (master 0 wins the first tie), `cnt`=0, `m1_pend`=0. Every output is 0 except `hold_o`, which follows its equation.
- Reset mid-access: `s_req_o` drops at that edge; no ack or err is issued for the aborted access.
- Latency, zero-wait memory:
  - cycle 0: gnt
  - cycle 1: `s_req_o`, with `s_ack_i` returned
  - cycle 2: `mX_ack_o`
  - Sustained throughput is one access per 2 cycles (IDLE, BUSY).
- A grant may occur in the same cycle as the previous access's `mX_ack_o`, because the state is already IDLE.
- Timeout: the ack/err pulse arrives TIMEOUT+1 cycles after gnt.
- Simultaneous continuous requests from both masters alternate strictly: 0, 1, 0, 1…

## Test plan
- Single fetch, memory acks in first busy cycle, addr 0x0000_0010, rdata 0x0010_0093:
  - gnt at c0, `s_req_o` at c1, `m0_ack_o` at c2 with rdata 0x0010_0093
  - `hold_o`=0 throughout
- Store from m1 (addr 0x100, wdata 0xDEADBEEF, wmask 4'b0011), memory acks after 3 wait cycles:
  - `s_we_o`=1 and s_* fields stable for 4 cycles
  - `hold_o`=1 from the req cycle until the `m1_ack_o` cycle
- Both masters request continuously from reset:
  - grant order is m0, m1, m0, m1
  - no cycle has two gnts; gnt in the same cycle as the previous ack
- TIMEOUT=4, memory never acks:
  - `m1_ack_o`=`m1_err_o`=1 exactly 5 cycles after gnt, rdata 0
  - state IDLE; next request is granted normally
- rst_n low during BUSY0:
  - `s_req_o`=0 after the edge, no `m0_ack_o`
  - after release the first tie goes to m0
- Spurious `s_ack_i` pulse in IDLE: no ack or err on either master.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/load-store masters, the arbiter and the memory.
// "slave" is the arbiter's view; "master" is the view of whatever drives the masters and the memory.
interface mem_arbiter_if;
  logic        m0_req_i;
  logic [31:0] m0_addr_i;
  logic        m0_gnt_o;
  logic        m0_ack_o;
  logic [31:0] m0_rdata_o;
  logic        m0_err_o;

  logic        m1_req_i;
  logic        m1_we_i;
  logic [31:0] m1_addr_i;
  logic [31:0] m1_wdata_i;
  logic [3:0]  m1_wmask_i;
  logic        m1_gnt_o;
  logic        m1_ack_o;
  logic [31:0] m1_rdata_o;
  logic        m1_err_o;

  logic        s_req_o;
  logic        s_we_o;
  logic [31:0] s_addr_o;
  logic [31:0] s_wdata_o;
  logic [3:0]  s_wmask_o;
  logic [31:0] s_rdata_i;
  logic        s_ack_i;

  logic        hold_o;

  modport slave (
    input  m0_req_i, m0_addr_i,
    output m0_gnt_o, m0_ack_o, m0_rdata_o, m0_err_o,
    input  m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_wmask_i,
    output m1_gnt_o, m1_ack_o, m1_rdata_o, m1_err_o,
    output s_req_o, s_we_o, s_addr_o, s_wdata_o, s_wmask_o,
    input  s_rdata_i, s_ack_i,
    output hold_o
  );

  modport master (
    output m0_req_i, m0_addr_i,
    input  m0_gnt_o, m0_ack_o, m0_rdata_o, m0_err_o,
    output m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_wmask_i,
    input  m1_gnt_o, m1_ack_o, m1_rdata_o, m1_err_o,
    input  s_req_o, s_we_o, s_addr_o, s_wdata_o, s_wmask_o,
    output s_rdata_i, s_ack_i,
    input  hold_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch (m0)
// and load/store (m1), with one access in flight, access timeout and pipeline hold.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic         clk,
  input logic         rst_n,
  mem_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BUSY0 = 2'd1;
  localparam logic [1:0] BUSY1 = 2'd2;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state_reg;
  logic        last_reg;
  logic [7:0]  cnt_reg;
  logic        pend_reg;
  logic        s_we_reg;
  logic [31:0] s_addr_reg;
  logic [31:0] s_wdata_reg;
  logic [3:0]  s_wmask_reg;
  logic [1:0]  ack_reg;
  logic [1:0]  err_reg;
  logic [31:0] rdata_reg [2];

  logic idle;
  logic gnt0;
  logic gnt1;
  logic sel;

  // Tie goes to whichever master was not served last.
  always_comb begin
    idle = (state_reg == IDLE);
    gnt0 = rst_n & idle & bus.m0_req_i & (~bus.m1_req_i | last_reg);
    gnt1 = rst_n & idle & bus.m1_req_i & (~bus.m0_req_i | ~last_reg);
    sel  = (state_reg == BUSY1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      last_reg     <= 1'b1;
      cnt_reg      <= 8'd0;
      pend_reg     <= 1'b0;
      s_we_reg     <= 1'b0;
      s_addr_reg   <= 32'd0;
      s_wdata_reg  <= 32'd0;
      s_wmask_reg  <= 4'd0;
      ack_reg      <= 2'b00;
      err_reg      <= 2'b00;
      rdata_reg[0] <= 32'd0;
      rdata_reg[1] <= 32'd0;
    end else begin
      ack_reg <= 2'b00;
      err_reg <= 2'b00;
      if (ack_reg[1]) begin
        pend_reg <= 1'b0;
      end
      case (state_reg)
        IDLE: begin
          if (gnt0) begin
            s_we_reg    <= 1'b0;
            s_addr_reg  <= bus.m0_addr_i;
            s_wdata_reg <= 32'd0;
            s_wmask_reg <= 4'd0;
            last_reg    <= 1'b0;
            cnt_reg     <= 8'd0;
            state_reg   <= BUSY0;
          end else if (gnt1) begin
            s_we_reg    <= bus.m1_we_i;
            s_addr_reg  <= bus.m1_addr_i;
            s_wdata_reg <= bus.m1_wdata_i;
            s_wmask_reg <= bus.m1_wmask_i;
            last_reg    <= 1'b1;
            cnt_reg     <= 8'd0;
            pend_reg    <= 1'b1;
            state_reg   <= BUSY1;
          end
        end
        default: begin
          cnt_reg <= cnt_reg + 8'd1;
          // A real ack on the final counted cycle still wins over the timeout.
          if (bus.s_ack_i) begin
            rdata_reg[sel] <= bus.s_rdata_i;
            ack_reg[sel]   <= 1'b1;
            state_reg      <= IDLE;
          end else if (cnt_reg == CNT_LAST) begin
            rdata_reg[sel] <= 32'd0;
            ack_reg[sel]   <= 1'b1;
            err_reg[sel]   <= 1'b1;
            state_reg      <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.m0_gnt_o   = gnt0;
  assign bus.m1_gnt_o   = gnt1;
  assign bus.m0_ack_o   = ack_reg[0];
  assign bus.m1_ack_o   = ack_reg[1];
  assign bus.m0_err_o   = err_reg[0];
  assign bus.m1_err_o   = err_reg[1];
  assign bus.m0_rdata_o = rdata_reg[0];
  assign bus.m1_rdata_o = rdata_reg[1];

  assign bus.s_req_o   = ~idle;
  assign bus.s_we_o    = s_we_reg;
  assign bus.s_addr_o  = s_addr_reg;
  assign bus.s_wdata_o = s_wdata_reg;
  assign bus.s_wmask_o = s_wmask_reg;

  assign bus.hold_o = (bus.m1_req_i | pend_reg) & ~ack_reg[1];
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (TIMEOUT=4): fetch, store, alternation, timeout,
// mid-access reset and spurious memory ack, each against hand-computed values.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter #(.TIMEOUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    bus.m0_req_i   = 1'b0;
    bus.m0_addr_i  = 32'd0;
    bus.m1_req_i   = 1'b0;
    bus.m1_we_i    = 1'b0;
    bus.m1_addr_i  = 32'd0;
    bus.m1_wdata_i = 32'd0;
    bus.m1_wmask_i = 4'd0;
    bus.s_ack_i    = 1'b0;
    bus.s_rdata_i  = 32'd0;
  endtask

  logic [8:0] exp_gnt0;
  logic [8:0] exp_gnt1;
  logic [8:0] exp_ack0;
  logic [8:0] exp_ack1;

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    // Reset state
    check("rst_s_req", bus.s_req_o, 0);
    check("rst_s_addr", bus.s_addr_o, 0);
    check("rst_s_we", bus.s_we_o, 0);
    check("rst_ack0", bus.m0_ack_o, 0);
    check("rst_ack1", bus.m1_ack_o, 0);
    check("rst_rdata1", bus.m1_rdata_o, 0);
    check("rst_hold", bus.hold_o, 0);
    bus.m1_req_i = 1'b1;
    #1;
    check("rst_hold_eq", bus.hold_o, 1);
    check("rst_gnt1", bus.m1_gnt_o, 0);
    bus.m1_req_i = 1'b0;
    tick();
    rst_n = 1'b1;

    // Single fetch, zero-wait memory
    bus.m0_req_i  = 1'b1;
    bus.m0_addr_i = 32'h0000_0010;
    #1;
    check("f_gnt0_c0", bus.m0_gnt_o, 1);
    check("f_gnt1_c0", bus.m1_gnt_o, 0);
    check("f_hold_c0", bus.hold_o, 0);
    tick();
    bus.m0_req_i  = 1'b0;
    bus.s_ack_i   = 1'b1;
    bus.s_rdata_i = 32'h0010_0093;
    #1;
    check("f_sreq_c1", bus.s_req_o, 1);
    check("f_saddr_c1", bus.s_addr_o, 32'h0000_0010);
    check("f_swe_c1", bus.s_we_o, 0);
    check("f_smask_c1", bus.s_wmask_o, 0);
    check("f_ack0_c1", bus.m0_ack_o, 0);
    tick();
    bus.s_ack_i = 1'b0;
    check("f_ack0_c2", bus.m0_ack_o, 1);
    check("f_rdata0_c2", bus.m0_rdata_o, 32'h0010_0093);
    check("f_err0_c2", bus.m0_err_o, 0);
    check("f_sreq_c2", bus.s_req_o, 0);
    check("f_hold_c2", bus.hold_o, 0);

    // Store from m1, memory acks after 3 wait cycles
    tick();
    bus.m1_req_i   = 1'b1;
    bus.m1_we_i    = 1'b1;
    bus.m1_addr_i  = 32'h0000_0100;
    bus.m1_wdata_i = 32'hDEAD_BEEF;
    bus.m1_wmask_i = 4'b0011;
    #1;
    check("st_gnt1_c0", bus.m1_gnt_o, 1);
    check("st_hold_c0", bus.hold_o, 1);
    for (int c = 1; c <= 4; c++) begin
      tick();
      bus.m1_req_i   = 1'b0;
      bus.m1_addr_i  = 32'hFFFF_FFFF;
      bus.m1_wdata_i = 32'h0;
      bus.m1_wmask_i = 4'b1111;
      bus.s_ack_i    = (c == 4);
      bus.s_rdata_i  = 32'h1234_5678;
      #1;
      check($sformatf("st_sreq_c%0d", c), bus.s_req_o, 1);
      check($sformatf("st_swe_c%0d", c), bus.s_we_o, 1);
      check($sformatf("st_saddr_c%0d", c), bus.s_addr_o, 32'h0000_0100);
      check($sformatf("st_swdata_c%0d", c), bus.s_wdata_o, 32'hDEAD_BEEF);
      check($sformatf("st_smask_c%0d", c), bus.s_wmask_o, 32'h3);
      check($sformatf("st_hold_c%0d", c), bus.hold_o, 1);
      check($sformatf("st_ack1_c%0d", c), bus.m1_ack_o, 0);
    end
    tick();
    bus.s_ack_i = 1'b0;
    bus.m1_we_i = 1'b0;
    check("st_ack1_c5", bus.m1_ack_o, 1);
    check("st_err1_c5", bus.m1_err_o, 0);
    check("st_rdata1_c5", bus.m1_rdata_o, 32'h1234_5678);
    check("st_hold_c5", bus.hold_o, 0);
    tick();
    check("st_ack1_c6", bus.m1_ack_o, 0);
    check("st_hold_c6", bus.hold_o, 0);

    // Both masters request continuously from reset
    clear_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_gnt0 = 9'h011;
    exp_gnt1 = 9'h044;
    exp_ack0 = 9'h044;
    exp_ack1 = 9'h110;
    bus.m0_addr_i = 32'h0000_0040;
    bus.m1_addr_i = 32'h0000_0800;
    for (int k = 0; k < 9; k++) begin
      if (k > 0) tick();
      bus.m0_req_i  = (k < 7);
      bus.m1_req_i  = (k < 7);
      bus.s_ack_i   = bus.s_req_o;
      bus.s_rdata_i = 32'hA5A5_0000 + 32'(k);
      #1;
      check($sformatf("rr_gnt0_k%0d", k), bus.m0_gnt_o, exp_gnt0[k]);
      check($sformatf("rr_gnt1_k%0d", k), bus.m1_gnt_o, exp_gnt1[k]);
      check($sformatf("rr_ack0_k%0d", k), bus.m0_ack_o, exp_ack0[k]);
      check($sformatf("rr_ack1_k%0d", k), bus.m1_ack_o, exp_ack1[k]);
    end
    check("rr_rdata1_k8", bus.m1_rdata_o, 32'hA5A5_0007);
    check("rr_rdata0_k8", bus.m0_rdata_o, 32'hA5A5_0005);
    bus.s_ack_i = 1'b0;

    // Timeout on m1 with a memory that never acks
    tick();
    bus.m1_req_i  = 1'b1;
    bus.m1_addr_i = 32'h0000_0200;
    #1;
    check("to_gnt1_c0", bus.m1_gnt_o, 1);
    for (int c = 1; c <= 4; c++) begin
      tick();
      bus.m1_req_i = 1'b0;
      check($sformatf("to_sreq_c%0d", c), bus.s_req_o, 1);
      check($sformatf("to_ack1_c%0d", c), bus.m1_ack_o, 0);
    end
    tick();
    check("to_ack1_c5", bus.m1_ack_o, 1);
    check("to_err1_c5", bus.m1_err_o, 1);
    check("to_rdata1_c5", bus.m1_rdata_o, 0);
    check("to_sreq_c5", bus.s_req_o, 0);
    bus.m0_req_i  = 1'b1;
    bus.m0_addr_i = 32'h0000_0044;
    #1;
    check("to_gnt0_c5", bus.m0_gnt_o, 1);
    tick();
    bus.m0_req_i  = 1'b0;
    bus.s_ack_i   = 1'b1;
    bus.s_rdata_i = 32'hCAFE_F00D;
    #1;
    check("to_saddr_c6", bus.s_addr_o, 32'h0000_0044);
    check("to_err1_c6", bus.m1_err_o, 0);
    tick();
    bus.s_ack_i = 1'b0;
    check("to_ack0_c7", bus.m0_ack_o, 1);
    check("to_err0_c7", bus.m0_err_o, 0);
    check("to_rdata0_c7", bus.m0_rdata_o, 32'hCAFE_F00D);

    // Reset while BUSY0, then first tie goes to m0
    tick();
    bus.m0_req_i  = 1'b1;
    bus.m0_addr_i = 32'h0000_0080;
    #1;
    check("rb_gnt0_c0", bus.m0_gnt_o, 1);
    tick();
    bus.m0_req_i = 1'b0;
    check("rb_sreq_c1", bus.s_req_o, 1);
    rst_n = 1'b0;
    tick();
    check("rb_sreq_c2", bus.s_req_o, 0);
    check("rb_ack0_c2", bus.m0_ack_o, 0);
    rst_n = 1'b1;
    tick();
    check("rb_ack0_c3", bus.m0_ack_o, 0);
    check("rb_err0_c3", bus.m0_err_o, 0);
    bus.m0_req_i = 1'b1;
    bus.m1_req_i = 1'b1;
    #1;
    check("rb_gnt0_tie", bus.m0_gnt_o, 1);
    check("rb_gnt1_tie", bus.m1_gnt_o, 0);
    check("rb_hold_tie", bus.hold_o, 1);
    tick();
    bus.m0_req_i  = 1'b0;
    bus.m1_req_i  = 1'b0;
    bus.s_ack_i   = 1'b1;
    bus.s_rdata_i = 32'h0BAD_F00D;
    tick();
    bus.s_ack_i = 1'b0;
    check("rb_ack0_after", bus.m0_ack_o, 1);

    // Spurious s_ack_i in IDLE
    tick();
    bus.s_ack_i   = 1'b1;
    bus.s_rdata_i = 32'h5555_5555;
    tick();
    bus.s_ack_i = 1'b0;
    check("sp_ack0", bus.m0_ack_o, 0);
    check("sp_ack1", bus.m1_ack_o, 0);
    check("sp_err0", bus.m0_err_o, 0);
    check("sp_err1", bus.m1_err_o, 0);
    check("sp_sreq", bus.s_req_o, 0);
    check("sp_rdata0", bus.m0_rdata_o, 32'h0BAD_F00D);
    tick();
    check("sp_ack0_n", bus.m0_ack_o, 0);
    check("sp_ack1_n", bus.m1_ack_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
